// File: rtl/instr_fetch_seq.sv
// Program sequencer: PC generation with IDLE/RUN/HALT control and a 4-entry target LUT.
// Optional executed-cycle counter enabled by defining CYCLE_CNT_EN.
module instr_fetch_seq #(
  parameter int unsigned   PW   = 10,
  parameter logic [PW-1:0] TGT0 = '0,
  parameter logic [PW-1:0] TGT1 = '0,
  parameter logic [PW-1:0] TGT2 = '0,
  parameter logic [PW-1:0] TGT3 = '0
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          Stall,
  input  logic          Jump,
  input  logic          BranchEn,
  input  logic          CondFlag,
  input  logic [1:0]    TargSel,
  input  logic          Ack,
  output logic [PW-1:0] PC,
  output logic          Running,
  output logic          Done,
  output logic [15:0]   CycleCnt
);

  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   pc_d;
  logic [PW-1:0]   tgt_c;
  logic            start_acc_c;

  // Constant target LUT, fully decoded by TargSel
  always_comb begin
    tgt_c = TGT0;
    case (TargSel)
      2'd0: tgt_c = TGT0;
      2'd1: tgt_c = TGT1;
      2'd2: tgt_c = TGT2;
      2'd3: tgt_c = TGT3;
      default: tgt_c = TGT0;
    endcase
  end

  assign start_acc_c = Start && (state_q != RUN);

  // Next-state and next-PC; Ack > Stall > Jump > taken branch > increment
  always_comb begin
    state_d = state_q;
    pc_d    = PC;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        if (Ack) begin
          state_d = HALT;
        end else if (Stall) begin
          pc_d = PC;
        end else if (Jump) begin
          pc_d = tgt_c;
        end else if (BranchEn && CondFlag) begin
          pc_d = PW'(PC + tgt_c);
        end else begin
          pc_d = PW'(PC + PW'(1));
        end
      end
      HALT: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      PC      <= '0;
      Running <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      PC      <= pc_d;
      Running <= (state_d == RUN);
      Done    <= (state_d == HALT);
    end
  end

`ifdef CYCLE_CNT_EN
  logic [CW-1:0] cnt_d;

  // Counts every RUN edge (stalls and Ack included), saturating, cleared on start
  always_comb begin
    cnt_d = CycleCnt;
    if (start_acc_c) begin
      cnt_d = '0;
    end else if ((state_q == RUN) && (CycleCnt != {CW{1'b1}})) begin
      cnt_d = CW'(CycleCnt + CW'(1));
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      CycleCnt <= '0;
    end else begin
      CycleCnt <= cnt_d;
    end
  end
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc_c;
  assign CycleCnt = CW'(0);
`endif

endmodule
